// File: rtl/seg_scroll_disp_pkg.sv
// Shared types and constants for the scrolling seven-segment display:
// scroll modes, the active-high hex segment table and the blank pattern.
package seg_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'd0,
        MODE_ROT_L  = 2'd1,
        MODE_ROT_R  = 2'd2,
        MODE_HOLD   = 2'd3
    } mode_t;

    localparam int IDX_W = 4;

    // Bits 7..1 = segments a..g, bit 0 = dp; a set bit lights the segment.
    localparam logic [7:0] SEG_HEX [16] = '{
        8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
        8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
    };

    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg_scroll_disp_if.sv
// Digit-buffer write port of the scrolling display: valid/ready handshake
// carrying a buffer index and a hex nibble, plus the bad-index error pulse.
interface seg_scroll_disp_if;
    import seg_pkg::*;

    logic             i_wr_valid;
    logic             o_wr_ready;
    logic [IDX_W-1:0] i_wr_idx;
    logic [3:0]       i_wr_data;
    logic             o_wr_err;

    modport master (
        output i_wr_valid,
        output i_wr_idx,
        output i_wr_data,
        input  o_wr_ready,
        input  o_wr_err
    );

    modport slave (
        input  i_wr_valid,
        input  i_wr_idx,
        input  i_wr_data,
        output o_wr_ready,
        output o_wr_err
    );

endinterface

// File: rtl/seg_scroll_disp_hex_dec.sv
// Combinational hex nibble to active-high seven-segment pattern decoder.
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_pat
);

    assign o_pat = SEG_HEX[i_nib];

endmodule

// File: rtl/seg_scroll_disp.sv
// N-digit seven-segment driver: writable hex buffer, prescaled scroll engine.
// Optional per-position blinking is enabled by defining SEG_SCROLL_BLINK_EN.
module seg_scroll_disp
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 5000000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  mode_t                         i_mode,
    seg_scroll_disp_if.slave              wr,
`ifdef SEG_SCROLL_BLINK_EN
    input  logic [NUM_DIGITS-1:0]         i_blink_mask,
`endif
    output logic [$clog2(NUM_DIGITS)-1:0] o_offset,
    output logic                          o_tick,
    output logic [8*NUM_DIGITS-1:0]       o_seg
);

    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int OFF_W = $clog2(NUM_DIGITS);
    localparam int SUM_W = OFF_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(NUM_DIGITS - 1);
    localparam logic [8*NUM_DIGITS-1:0] SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [CNT_W-1:0]        count_q, count_d;
    logic [OFF_W-1:0]        offset_q, offset_d;
    logic                    tick_q, tick_d;
    logic                    wr_ready_q, wr_ready_d;
    logic                    wr_err_q, wr_err_d;
    logic [3:0]              dig_buf_q [NUM_DIGITS];
    logic [3:0]              dig_buf_d [NUM_DIGITS];
    logic [8*NUM_DIGITS-1:0] seg_q, seg_d;

    logic                    tick;
    logic                    wr_fire;
    logic                    idx_ok;
    logic [7:0]              pat [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank;
    logic [7:0]              lit;

    assign tick    = (count_q == CNT_LAST);
    assign wr_fire = wr.i_wr_valid && wr_ready_q;
    assign idx_ok  = ({1'b0, wr.i_wr_idx} < (IDX_W + 1)'(NUM_DIGITS));

`ifdef SEG_SCROLL_BLINK_EN
    logic blink_ph_q, blink_ph_d;

    assign blink_ph_d = tick ? ~blink_ph_q : blink_ph_q;
    assign blank      = blink_ph_q ? i_blink_mask : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_ph_q <= 1'b0;
        end else begin
            blink_ph_q <= blink_ph_d;
        end
    end
`else
    assign blank = '0;
`endif

    // Display position k reads buffer slot (k + offset) mod N.
    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dig
        logic [SUM_W-1:0] raw;
        logic [OFF_W-1:0] idx;

        assign raw = SUM_W'(k) + {1'b0, offset_q};
        assign idx = (raw >= SUM_W'(NUM_DIGITS)) ? OFF_W'(raw - SUM_W'(NUM_DIGITS))
                                                 : raw[OFF_W-1:0];

        seg_hex_dec u_dec (
            .i_nib (dig_buf_q[idx]),
            .o_pat (pat[k])
        );
    end

    always_comb begin
        count_d    = tick ? '0 : count_q + CNT_W'(1);
        tick_d     = tick;
        wr_ready_d = 1'b1;
        wr_err_d   = wr_fire && !idx_ok;

        offset_d = offset_q;
        case (i_mode)
            MODE_STATIC: offset_d = '0;
            MODE_ROT_L: begin
                if (tick) offset_d = (offset_q == OFF_LAST) ? '0 : offset_q + OFF_W'(1);
            end
            MODE_ROT_R: begin
                if (tick) offset_d = (offset_q == '0) ? OFF_LAST : offset_q - OFF_W'(1);
            end
            default: offset_d = offset_q;
        endcase

        for (int i = 0; i < NUM_DIGITS; i++) begin
            dig_buf_d[i] = dig_buf_q[i];
            if (wr_fire && idx_ok && (wr.i_wr_idx == IDX_W'(i))) begin
                dig_buf_d[i] = wr.i_wr_data;
            end
        end

        // Blanking is applied before polarity so a blanked digit is always unlit.
        seg_d = '0;
        lit   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            lit    = blank[k] ? SEG_BLANK : pat[k];
            lit[0] = 1'b0;
            seg_d[8*k +: 8] = (ACTIVE_LOW != 0) ? ~lit : lit;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            offset_q   <= '0;
            tick_q     <= 1'b0;
            wr_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
            seg_q      <= SEG_OFF;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                dig_buf_q[i] <= 4'(i);
            end
        end else begin
            count_q    <= count_d;
            offset_q   <= offset_d;
            tick_q     <= tick_d;
            wr_ready_q <= wr_ready_d;
            wr_err_q   <= wr_err_d;
            seg_q      <= seg_d;
            dig_buf_q  <= dig_buf_d;
        end
    end

    assign wr.o_wr_ready = wr_ready_q;
    assign wr.o_wr_err   = wr_err_q;
    assign o_offset      = offset_q;
    assign o_tick        = tick_q;
    assign o_seg         = seg_q;

endmodule

// File: tb/tb_seg_scroll_disp.sv
// Scoreboard bench for seg_scroll_disp (6 digits, 4-cycle scroll tick, active-low).
module tb_seg_scroll_disp;
    import seg_pkg::*;

    localparam int N   = 6;
    localparam int DIV = 4;

    localparam logic [2:0] K_SEG  = 3'd0;
    localparam logic [2:0] K_OFF  = 3'd1;
    localparam logic [2:0] K_RDY  = 3'd2;
    localparam logic [2:0] K_ERR  = 3'd3;
    localparam logic [2:0] K_TICK = 3'd4;

    localparam logic [47:0] SEG_ALL1  = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] SEG_RST   = 48'h49_99_0D_25_9F_03;
    localparam logic [47:0] SEG_OFF1  = 48'h03_49_99_0D_25_9F;
    localparam logic [47:0] SEG_OFF5  = 48'h99_0D_25_9F_03_49;
    localparam logic [47:0] SEG_WA    = 48'h49_99_0D_11_9F_03;
    localparam logic [47:0] SEG_WF_O1 = 48'h03_49_99_0D_11_71;
    localparam logic [47:0] SEG_WF_O0 = 48'h49_99_0D_11_71_03;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    mode_t       mode = MODE_STATIC;
    logic [2:0]  offset;
    logic        tick;
    logic [47:0] seg;
`ifdef SEG_SCROLL_BLINK_EN
    logic [N-1:0] blink_mask = '0;
`endif

    seg_scroll_disp_if wr_if ();

    seg_scroll_disp #(
        .NUM_DIGITS (N),
        .CLK_DIV    (DIV),
        .ACTIVE_LOW (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_mode       (mode),
        .wr           (wr_if),
`ifdef SEG_SCROLL_BLINK_EN
        .i_blink_mask (blink_mask),
`endif
        .o_offset     (offset),
        .o_tick       (tick),
        .o_seg        (seg)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int          due;
        logic [2:0]  kind;
        logic [47:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void exp_at(input int due, input logic [2:0] kind, input logic [47:0] val);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.val  = val;
        sb.push_back(e);
    endfunction

    function automatic string kname(input logic [2:0] kind);
        case (kind)
            K_SEG:   return "o_seg";
            K_OFF:   return "o_offset";
            K_RDY:   return "o_wr_ready";
            K_ERR:   return "o_wr_err";
            default: return "o_tick";
        endcase
    endfunction

    // Monitor: after edge cyc, every entry due at this edge is compared.
    always @(negedge clk) begin
        logic [47:0] act;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due <= cyc) begin
                case (sb[i].kind)
                    K_SEG:   act = seg;
                    K_OFF:   act = {45'd0, offset};
                    K_RDY:   act = {47'd0, wr_if.o_wr_ready};
                    K_ERR:   act = {47'd0, wr_if.o_wr_err};
                    default: act = {47'd0, tick};
                endcase
                n_cmp++;
                if (sb[i].due < cyc || act !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s after edge %0d: got %h, expected %h",
                             kname(sb[i].kind), sb[i].due, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic step_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_wr(input logic v, input logic [3:0] idx, input logic [3:0] data);
        wr_if.i_wr_valid = v;
        wr_if.i_wr_idx   = idx;
        wr_if.i_wr_data  = data;
    endtask

    initial begin
        drive_wr(1'b0, 4'd0, 4'd0);

        // Reset held for three edges, then released.
        for (int e = 1; e <= 3; e++) exp_at(e, K_SEG, SEG_ALL1);
        exp_at(1, K_RDY, 48'd0);
        exp_at(1, K_OFF, 48'd0);
        exp_at(2, K_TICK, 48'd0);
        exp_at(2, K_ERR, 48'd0);
        exp_at(3, K_RDY, 48'd0);
        exp_at(4, K_SEG, SEG_RST);
        exp_at(4, K_RDY, 48'd1);
        exp_at(4, K_OFF, 48'd0);
        step_to(3);
        rst = 1'b0;

        // Rotate left through six ticks; ticks land on edges 7, 11, ...
        step_to(4);
        n_cmp++;
        if (seg !== SEG_RST) begin
            n_bad++;
            $display("FAIL direct o_seg after edge 4: got %h, expected %h", seg, SEG_RST);
        end
        n_cmp++;
        if (wr_if.o_wr_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL direct o_wr_ready after edge 4: got %b", wr_if.o_wr_ready);
        end
        mode = MODE_ROT_L;
        for (int t = 0; t < 6; t++) begin
            exp_at(6 + 4*t, K_OFF, 48'(t));
            exp_at(7 + 4*t, K_OFF, 48'((t + 1) % 6));
        end
        exp_at(6, K_TICK, 48'd0);
        exp_at(7, K_TICK, 48'd1);
        exp_at(8, K_TICK, 48'd0);
        exp_at(8, K_SEG, SEG_OFF1);
        exp_at(10, K_TICK, 48'd0);
        exp_at(11, K_TICK, 48'd1);

        // Rotate right from offset 0 wraps to 5.
        step_to(27);
        n_cmp++;
        if (offset !== 3'd0) begin
            n_bad++;
            $display("FAIL direct o_offset after edge 27: got %0d, expected 0", offset);
        end
        mode = MODE_ROT_R;
        exp_at(30, K_OFF, 48'd0);
        exp_at(31, K_OFF, 48'd5);
        exp_at(32, K_SEG, SEG_OFF5);

        step_to(31);
        n_cmp++;
        if (offset !== 3'd5) begin
            n_bad++;
            $display("FAIL direct o_offset after edge 31: got %0d, expected 5", offset);
        end
        mode = MODE_STATIC;
        exp_at(32, K_OFF, 48'd0);
        exp_at(33, K_SEG, SEG_RST);

        // Valid write, then two out-of-range writes (idx 7, idx 6 == N).
        step_to(33);
        drive_wr(1'b1, 4'd2, 4'hA);
        exp_at(34, K_ERR, 48'd0);
        exp_at(34, K_SEG, SEG_RST);
        exp_at(35, K_SEG, SEG_WA);
        step_to(34);
        drive_wr(1'b0, 4'd0, 4'd0);

        step_to(35);
        drive_wr(1'b1, 4'd7, 4'h3);
        exp_at(36, K_ERR, 48'd1);
        exp_at(37, K_ERR, 48'd1);
        exp_at(38, K_ERR, 48'd0);
        exp_at(38, K_SEG, SEG_WA);
        step_to(36);
        drive_wr(1'b1, 4'd6, 4'h3);
        step_to(37);
        drive_wr(1'b0, 4'd0, 4'd0);
        mode = MODE_ROT_L;

        // Write lands on the same edge (39) as a rotate-left tick.
        step_to(38);
        drive_wr(1'b1, 4'd1, 4'hF);
        exp_at(39, K_SEG, SEG_WA);
        exp_at(39, K_OFF, 48'd1);
        exp_at(40, K_SEG, SEG_WF_O1);
        step_to(39);
        drive_wr(1'b0, 4'd0, 4'd0);
        mode = MODE_HOLD;
        exp_at(43, K_OFF, 48'd1);
        exp_at(43, K_TICK, 48'd1);
        exp_at(47, K_OFF, 48'd1);
        exp_at(51, K_OFF, 48'd1);
        exp_at(51, K_SEG, SEG_WF_O1);

        step_to(51);
        n_cmp++;
        if (offset !== 3'd1) begin
            n_bad++;
            $display("FAIL direct o_offset after edge 51: got %0d, expected 1", offset);
        end
        mode = MODE_STATIC;
        exp_at(52, K_OFF, 48'd0);
        exp_at(53, K_SEG, SEG_WF_O0);

        // Reset during an in-flight write drops it and restores the buffer.
        step_to(53);
        rst = 1'b1;
        drive_wr(1'b1, 4'd0, 4'h8);
        exp_at(54, K_SEG, SEG_ALL1);
        exp_at(54, K_RDY, 48'd0);
        exp_at(54, K_OFF, 48'd0);
        exp_at(54, K_ERR, 48'd0);
        exp_at(55, K_SEG, SEG_RST);
        exp_at(55, K_RDY, 48'd1);
        step_to(54);
        rst = 1'b0;
        drive_wr(1'b0, 4'd0, 4'd0);

`ifdef SEG_SCROLL_BLINK_EN
        // Blink phase toggles on ticks at edges 58, 62, 66.
        step_to(55);
        mode = MODE_HOLD;
        blink_mask = 6'b000001;
        exp_at(58, K_SEG, SEG_RST);
        exp_at(59, K_SEG, {SEG_RST[47:8], 8'hFF});
        exp_at(62, K_SEG, {SEG_RST[47:8], 8'hFF});
        exp_at(63, K_SEG, SEG_RST);
        exp_at(67, K_SEG, {SEG_RST[47:8], 8'hFF});
`endif

        step_to(70);
        while (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s due after edge %0d was never checked, expected %h",
                     kname(sb[0].kind), sb[0].due, sb[0].val);
            void'(sb.pop_front());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
